// File: rtl/dmg_div_timer.sv
// DMG DIV/TIMA/TMA/TAC timer: free-running divider, timer counter with
// delayed TMA reload, timer interrupt request and 16 Hz oscillator tap.
module dmg_div_timer #(
  parameter int unsigned DIV_WIDTH    = 18,
  parameter int unsigned SLOW_TAP     = 17,
  parameter int unsigned RELOAD_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_ENA,
  input  logic       SEL,
  input  logic [1:0] ADDR,
  input  logic       WR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       IRQ_TIMER,
  input  logic       IRQ_CLR,
  output logic       SIXTEEN_HZ
);

  localparam int unsigned WCNT_W = (RELOAD_TICKS > 1) ? $clog2(RELOAD_TICKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RELOAD
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [7:0]            tima_q, tima_d;
  logic [7:0]            tma_q, tma_d;
  logic [2:0]            tac_q, tac_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  sig_q, sig_d;
  logic                  irq_q, irq_d;
  logic                  hz_q, hz_d;

  logic wr_en, wr_div, wr_tima, wr_tma, wr_tac;
  logic tap_bit, fall;

  assign wr_en   = SEL & WR;
  assign wr_div  = wr_en & (ADDR == 2'd0);
  assign wr_tima = wr_en & (ADDR == 2'd1);
  assign wr_tma  = wr_en & (ADDR == 2'd2);
  assign wr_tac  = wr_en & (ADDR == 2'd3);

  // Divider bit selected by the TAC clock-select field.
  always_comb begin
    tap_bit = 1'b0;
    case (tac_q[1:0])
      2'b00:   tap_bit = cnt_q[9];
      2'b01:   tap_bit = cnt_q[3];
      2'b10:   tap_bit = cnt_q[5];
      default: tap_bit = cnt_q[7];
    endcase
  end

  // Timer input and its falling edge; write-induced drops count too.
  assign sig_d = tac_q[2] & tap_bit;
  assign fall  = sig_q & ~sig_d;

  // Next-state logic for divider, registers and the reload sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tima_d  = tima_q;
    tma_d   = tma_q;
    tac_d   = tac_q;
    wcnt_d  = wcnt_q;
    irq_d   = irq_q;

    if (wr_div) begin
      cnt_d = '0;
    end else if (CLK_ENA) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end

    if (wr_tac) tac_d = DIN[2:0];
    if (wr_tma) tma_d = DIN;
    if (IRQ_CLR) irq_d = 1'b0;

    case (state_q)
      ST_RELOAD: begin
        // tma_d already carries a same-cycle TMA write
        tima_d  = tma_d;
        irq_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        if (wr_tima) begin
          tima_d  = DIN;
          state_d = ST_IDLE;
        end else begin
          if ((state_q == ST_WAIT) && CLK_ENA) begin
            if (wcnt_q == '0) begin
              state_d = ST_RELOAD;
            end else begin
              wcnt_d = wcnt_q - WCNT_W'(1);
            end
          end
          if (fall) begin
            if ((state_q == ST_IDLE) && (tima_q == 8'hFF)) begin
              tima_d  = 8'h00;
              state_d = ST_WAIT;
              wcnt_d  = WCNT_W'(RELOAD_TICKS - 1);
            end else begin
              tima_d = tima_q + 8'd1;
            end
          end
        end
      end
    endcase

    hz_d = cnt_d[SLOW_TAP];
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tima_q  <= '0;
      tma_q   <= '0;
      tac_q   <= '0;
      wcnt_q  <= '0;
      sig_q   <= 1'b0;
      irq_q   <= 1'b0;
      hz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      wcnt_q  <= wcnt_d;
      sig_q   <= sig_d;
      irq_q   <= irq_d;
      hz_q    <= hz_d;
    end
  end

  // Read mux; unselected bus reads as all ones.
  always_comb begin
    DOUT = 8'hFF;
    if (SEL) begin
      case (ADDR)
        2'd0:    DOUT = cnt_q[15:8];
        2'd1:    DOUT = tima_q;
        2'd2:    DOUT = tma_q;
        default: DOUT = {5'b11111, tac_q};
      endcase
    end
  end

  assign IRQ_TIMER  = irq_q;
  assign SIXTEEN_HZ = hz_q;

endmodule

// File: tb/tb_dmg_div_timer.sv
// Bench for dmg_div_timer: directed sequences, a read-decode table and a
// randomized run compared against a behavioural timer model.
module tb_dmg_div_timer;

  localparam int RELOAD_TICKS = 4;

  logic       clk = 1'b0;
  logic       rst, ena, sel, wr, clr;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout, dout2;
  logic       irq, irq2, hz, hz2;

  int checks = 0;
  int failures = 0;

  always #50 clk = ~clk;

  dmg_div_timer u_dut (
    .CLK(clk), .RESET(rst), .CLK_ENA(ena), .SEL(sel), .ADDR(addr), .WR(wr),
    .DIN(din), .DOUT(dout), .IRQ_TIMER(irq), .IRQ_CLR(clr), .SIXTEEN_HZ(hz)
  );

  // Short slow tap so the 16 Hz output path can be exercised quickly.
  dmg_div_timer #(.SLOW_TAP(9)) u_fast (
    .CLK(clk), .RESET(rst), .CLK_ENA(ena), .SEL(sel), .ADDR(addr), .WR(wr),
    .DIN(din), .DOUT(dout2), .IRQ_TIMER(irq2), .IRQ_CLR(clr), .SIXTEEN_HZ(hz2)
  );

  // Behavioural model: integers, a tick countdown to the reload and a
  // pending-reload flag.
  int m_cnt, m_tima, m_tma, m_tac, m_wait;
  bit m_sig_prev, m_reload, m_irq, m_hz;
  int tap_tbl [4] = '{9, 3, 5, 7};

  always @(posedge clk) begin
    bit we, sig, fall, was_wait;
    if (rst) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_wait = 0;
      m_sig_prev = 0; m_reload = 0; m_irq = 0; m_hz = 0;
    end else begin
      we   = sel && wr;
      sig  = ((m_tac >> 2) & 1) != 0 && ((m_cnt >> tap_tbl[m_tac & 3]) & 1) != 0;
      fall = m_sig_prev && !sig;
      m_sig_prev = sig;
      if (we && addr == 2'd0) m_cnt = 0;
      else if (ena) m_cnt = (m_cnt + 1) % (1 << 18);
      m_hz = ((m_cnt >> 17) & 1) != 0;
      if (we && addr == 2'd3) m_tac = int'(din) & 7;
      if (we && addr == 2'd2) m_tma = int'(din);
      if (m_reload) begin
        m_tima = m_tma; m_irq = 1; m_reload = 0; m_wait = 0;
      end else begin
        if (clr) m_irq = 0;
        if (we && addr == 2'd1) begin
          m_tima = int'(din); m_wait = 0;
        end else begin
          was_wait = m_wait > 0;
          if (was_wait && ena) begin
            m_wait--;
            if (m_wait == 0) m_reload = 1;
          end
          if (fall) begin
            if (!was_wait && m_tima == 255) begin
              m_tima = 0; m_wait = RELOAD_TICKS;
            end else begin
              m_tima = (m_tima + 1) & 255;
            end
          end
        end
      end
    end
  end

  function automatic int m_dout(bit s, int a);
    if (!s) return 255;
    case (a)
      0:       return (m_cnt >> 8) & 255;
      1:       return m_tima;
      2:       return m_tma;
      default: return 248 | m_tac;
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    ena = 1'b1;
    repeat (n) cyc();
    ena = 1'b0;
  endtask

  task automatic wr_reg(logic [1:0] a, logic [7:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; din = d;
    cyc();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic chk_rd(string nm, logic [1:0] a, logic [7:0] e);
    sel = 1'b1; wr = 1'b0; addr = a;
    #1;
    chk(nm, int'(dout), int'(e));
    sel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       sel;
    logic [1:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  initial begin
    rst = 1'b1; ena = 1'b0; sel = 1'b0; wr = 1'b0; clr = 1'b0;
    addr = 2'd0; din = 8'h00;
    cyc(); cyc();
    rst = 1'b0;

    // Reset values
    chk_rd("rst_div", 2'd0, 8'h00);
    chk_rd("rst_tima", 2'd1, 8'h00);
    chk_rd("rst_tma", 2'd2, 8'h00);
    chk_rd("rst_tac", 2'd3, 8'hF8);
    chk("rst_irq", int'(irq), 0);
    chk("rst_hz", int'(hz), 0);

    // Divider read-back and slow tap edges (fast instance taps bit 9)
    tick(255);
    chk_rd("div_255", 2'd0, 8'h00);
    tick(1);
    chk_rd("div_256", 2'd0, 8'h01);
    tick(255);
    chk("hz_511", int'(hz2), 0);
    tick(1);
    chk("hz_512", int'(hz2), 1);
    chk_rd("div_512", 2'd0, 8'h02);
    tick(511);
    chk("hz_1023", int'(hz2), 1);
    tick(1);
    chk("hz_1024", int'(hz2), 0);
    sel = 1'b1; addr = 2'd0; #1;
    chk("fast_div_1024", int'(dout2), 8'h04);
    sel = 1'b0;
    chk("main_hz_low", int'(hz), 0);

    // Read decode table
    do_reset();
    tick(12'h234);
    wr_reg(2'd1, 8'hA5);
    wr_reg(2'd2, 8'h3C);
    wr_reg(2'd3, 8'hFB);
    vecs[0] = '{1'b1, 2'd0, 8'h02};
    vecs[1] = '{1'b1, 2'd1, 8'hA5};
    vecs[2] = '{1'b1, 2'd2, 8'h3C};
    vecs[3] = '{1'b1, 2'd3, 8'hFB};
    vecs[4] = '{1'b0, 2'd0, 8'hFF};
    vecs[5] = '{1'b0, 2'd1, 8'hFF};
    vecs[6] = '{1'b0, 2'd2, 8'hFF};
    vecs[7] = '{1'b0, 2'd3, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; addr = vecs[i].addr; #1;
      chk($sformatf("dout_vec%0d", i), int'(dout), int'(vecs[i].exp));
      sel = 1'b0;
    end

    // Overflow, delayed reload and interrupt
    do_reset();
    wr_reg(2'd3, 8'h05); wr_reg(2'd1, 8'hFE); wr_reg(2'd2, 8'h42);
    tick(16);
    chk_rd("ovf_tima_t16", 2'd1, 8'hFE);
    cyc();
    chk_rd("ovf_tima_ff", 2'd1, 8'hFF);
    tick(16);
    cyc();
    chk_rd("ovf_tima_00", 2'd1, 8'h00);
    chk("ovf_irq_0", int'(irq), 0);
    tick(3);
    chk_rd("ovf_wait3", 2'd1, 8'h00);
    tick(1);
    chk_rd("ovf_wait4", 2'd1, 8'h00);
    chk("ovf_irq_wait4", int'(irq), 0);
    cyc();
    chk_rd("ovf_reload", 2'd1, 8'h42);
    chk("ovf_irq_1", int'(irq), 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("ovf_irq_clr", int'(irq), 0);

    // TIMA write during the wait cancels the reload
    do_reset();
    wr_reg(2'd3, 8'h05); wr_reg(2'd1, 8'hFF); wr_reg(2'd2, 8'h42);
    tick(16); cyc();
    tick(2);
    wr_reg(2'd1, 8'h10);
    tick(10);
    chk_rd("cancel_tima", 2'd1, 8'h10);
    chk("cancel_irq", int'(irq), 0);

    // DIV and TAC write glitches
    do_reset();
    wr_reg(2'd3, 8'h05);
    tick(8); cyc();
    wr_reg(2'd0, 8'h5A); cyc();
    chk_rd("glitch_div_tima", 2'd1, 8'h01);
    chk_rd("glitch_div_cnt", 2'd0, 8'h00);
    tick(7); cyc();
    wr_reg(2'd0, 8'h00); cyc();
    chk_rd("noglitch_tima", 2'd1, 8'h01);
    tick(8); cyc();
    wr_reg(2'd3, 8'h01); cyc();
    chk_rd("glitch_tac_tima", 2'd1, 8'h02);
    chk_rd("glitch_tac_rd", 2'd3, 8'hF9);

    // TMA write in the reload cycle, then reset in mid-wait
    do_reset();
    wr_reg(2'd3, 8'h05); wr_reg(2'd1, 8'hFF); wr_reg(2'd2, 8'h42);
    tick(16); cyc();
    tick(4);
    wr_reg(2'd2, 8'h99);
    chk_rd("rl_tma_tima", 2'd1, 8'h99);
    chk_rd("rl_tma_tma", 2'd2, 8'h99);
    chk("rl_tma_irq", int'(irq), 1);
    clr = 1'b1; cyc(); clr = 1'b0;
    wr_reg(2'd1, 8'hFF);
    tick(12); cyc();
    tick(2);
    do_reset();
    chk_rd("midrst_tima", 2'd1, 8'h00);
    chk_rd("midrst_tma", 2'd2, 8'h00);
    chk_rd("midrst_tac", 2'd3, 8'hF8);
    chk("midrst_irq", int'(irq), 0);
    tick(10);
    chk("midrst_irq_late", int'(irq), 0);
    chk_rd("midrst_tima_late", 2'd1, 8'h00);

    // Tick enable held low: state frozen, writes still land
    do_reset();
    wr_reg(2'd3, 8'h05);
    tick(300);
    chk_rd("ena_tima_300", 2'd1, 8'h12);
    chk_rd("ena_div_300", 2'd0, 8'h01);
    repeat (100) cyc();
    chk_rd("ena0_tima", 2'd1, 8'h12);
    chk_rd("ena0_div", 2'd0, 8'h01);
    chk("ena0_hz", int'(hz), 0);
    wr_reg(2'd2, 8'h77);
    chk_rd("ena0_tma_wr", 2'd2, 8'h77);
    wr_reg(2'd1, 8'h30);
    chk_rd("ena0_tima_wr", 2'd1, 8'h30);
    chk_rd("ena0_div_after", 2'd0, 8'h01);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      ena  = $urandom_range(0, 3) != 0;
      sel  = $urandom_range(0, 1) != 0;
      wr   = $urandom_range(0, 5) == 0;
      addr = 2'($urandom_range(0, 3));
      din  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      clr  = $urandom_range(0, 15) == 0;
      rst  = $urandom_range(0, 999) == 0;
      cyc();
      chk("rnd_dout", int'(dout), m_dout(sel, int'(addr)));
      chk("rnd_irq", int'(irq), int'(m_irq));
      chk("rnd_hz", int'(hz), int'(m_hz));
    end
    rst = 1'b0; ena = 1'b0; sel = 1'b0; wr = 1'b0; clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
